// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared UART receiver definitions: FSM state encoding, default
//            bit divisors and the bit-timer counter width.
// Contents : rx_state_t, C_DIV_FAST_DEFAULT, C_DIV_SLOW_DEFAULT, C_CNT_W,
//            half_div()
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Receiver FSM states; the same encodings are used by control and the
    // transmitter so debug taps read consistently across the UART.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Clock cycles per bit at 50 MHz.
    localparam int unsigned C_DIV_FAST_DEFAULT = 434;   // 115200 baud
    localparam int unsigned C_DIV_SLOW_DEFAULT = 5208;  // 9600 baud

    // Bit counter width; must hold the slowest divisor.
    localparam int unsigned C_CNT_W = 13;

    // Half-bit interval used to reach the middle of the start bit.
    function automatic logic [C_CNT_W-1:0] half_div(input logic [C_CNT_W-1:0] div);
        return div >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Bit-interval counter for the UART receiver. Counts 0..limit-1,
//            where limit is div (full bit) or div/2 (half bit), and emits a
//            one-cycle tick on the last count before wrapping.
// Ports    : clk     - system clock
//            reset   - asynchronous active-low reset
//            div     - cycles per bit (latched by the caller per frame)
//            half    - 1 selects div/2, 0 selects div
//            restart - holds the counter at zero, suppresses tick
//            tick    - one-cycle strobe at the end of each interval
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer
    import uart_rx_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [C_CNT_W-1:0] div,
    input  logic               half,
    input  logic               restart,
    output logic               tick
);

    localparam logic [C_CNT_W-1:0] C_ONE = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_limit;

    assign w_limit = half ? half_div(div) : div;
    assign tick    = !restart && (r_cnt == (w_limit - C_ONE));

    // Wrapping on tick means the next interval starts from zero without the
    // FSM having to issue a restart between phases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART serial receiver. Synchronises rxo, qualifies start bits at
//            mid-bit, samples 7/8 data bits, optional even parity and the
//            stop bit, then presents the character with a one-cycle strobe.
// Ports    : clk        - system clock
//            reset      - asynchronous active-low reset
//            paritys    - 1 = even parity bit present
//            bauds      - 1 = DIV_FAST, 0 = DIV_SLOW
//            dls        - 1 = 8 data bits, 0 = 7 data bits
//            rxo        - asynchronous serial line, idle high
//            rx_data    - received character (bit 7 = 0 in 7-bit mode)
//            rx_valid   - one-cycle strobe qualifying rx_data and flags
//            parity_err - parity mismatch on the last frame
//            frame_err  - stop bit sampled low on the last frame
//            rx_busy    - frame in progress (START through stop sample)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_FAST = C_DIV_FAST_DEFAULT,
    parameter int unsigned DIV_SLOW = C_DIV_SLOW_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       paritys,
    input  logic       bauds,
    input  logic       dls,
    input  logic       rxo,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [C_CNT_W-1:0] C_DIV_FAST = C_CNT_W'(DIV_FAST);
    localparam logic [C_CNT_W-1:0] C_DIV_SLOW = C_CNT_W'(DIV_SLOW);

    // ------------------------------------------------------------------
    // Line synchroniser and falling-edge detector
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_fall;
    logic w_sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rxo;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall   = r_prev & ~r_sync2;
    assign w_sample = r_sync2;

    // ------------------------------------------------------------------
    // Bit timer: half-bit in START, full bit elsewhere, held in IDLE
    // ------------------------------------------------------------------
    rx_state_t          r_state;
    logic [C_CNT_W-1:0] r_div;
    logic               w_tick;
    logic               w_half;
    logic               w_restart;

    assign w_half    = (r_state == ST_START);
    assign w_restart = (r_state == ST_IDLE);

    uart_bit_timer u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .div     (r_div),
        .half    (w_half),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // ------------------------------------------------------------------
    // Receive FSM, shifter and parity accumulator
    // ------------------------------------------------------------------
    logic       r_paritys;    // frame-latched selects
    logic       r_dls;
    logic [7:0] r_shift;
    logic [2:0] r_idx;
    logic       r_par;        // running XOR of data bits
    logic       r_par_err;    // result of the parity sample
    logic       r_wait_high;  // set after a break; blocks restart until line rises
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_parity_err;
    logic       r_frame_err;
    logic       r_rx_busy;
    logic [2:0] w_last_idx;

    assign w_last_idx = r_dls ? 3'd7 : 3'd6;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_div        <= C_DIV_SLOW;
            r_paritys    <= 1'b0;
            r_dls        <= 1'b1;
            r_shift      <= '0;
            r_idx        <= '0;
            r_par        <= 1'b0;
            r_par_err    <= 1'b0;
            r_wait_high  <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_busy    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_sync2) begin
                r_wait_high <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !r_wait_high) begin
                        r_state   <= ST_START;
                        r_div     <= bauds ? C_DIV_FAST : C_DIV_SLOW;
                        r_paritys <= paritys;
                        r_dls     <= dls;
                        r_shift   <= '0;
                        r_idx     <= '0;
                        r_par     <= 1'b0;
                        r_par_err <= 1'b0;
                        r_rx_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (!w_sample) begin
                            r_state <= ST_DATA;
                        end else begin
                            // Line back high at mid start bit: glitch.
                            r_state   <= ST_IDLE;
                            r_rx_busy <= 1'b0;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        r_shift[r_idx] <= w_sample;
                        r_par          <= r_par ^ w_sample;
                        if (r_idx == w_last_idx) begin
                            r_state <= r_paritys ? ST_PARITY : ST_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_tick) begin
                        r_par_err <= r_par ^ w_sample;
                        r_state   <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        r_rx_data    <= r_shift;
                        r_parity_err <= r_paritys & r_par_err;
                        r_frame_err  <= ~w_sample;
                        r_rx_valid   <= 1'b1;
                        r_rx_busy    <= 1'b0;
                        r_state      <= ST_IDLE;
                        if (!w_sample) begin
                            r_wait_high <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_rx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign rx_busy    = r_rx_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx. Drives serial frames
//            on the falling clock edge and checks strobes, data and flags.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int C_FAST = 434;
    localparam int C_SLOW = 5208;

    logic       clk = 1'b0;
    logic       reset;
    logic       paritys;
    logic       bauds;
    logic       dls;
    logic       rxo;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .paritys    (paritys),
        .bauds      (bauds),
        .dls        (dls),
        .rxo        (rxo),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    // 2-unit clock period: 434 cycles per bit = 868 time units.
    always #1 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Strobe monitor: counts rx_valid pulses and captures the delivered word.
    int         n_strobe   = 0;
    int         strobe_cyc = 0;
    logic [7:0] cap_data   = 8'h00;
    logic       cap_perr   = 1'b0;
    logic       cap_ferr   = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_strobe++;
            strobe_cyc = cyc;
            cap_data   = rx_data;
            cap_perr   = parity_err;
            cap_ferr   = frame_err;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a level for n cycles; called on a falling edge.
    task automatic hold(input logic v, input int n);
        rxo = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input logic par_bit, input logic stop_bit, input int div);
        hold(1'b0, div);
        for (int i = 0; i < nbits; i++) hold(d[i], div);
        if (par_en) hold(par_bit, div);
        hold(stop_bit, div);
    endtask

    int base;
    int c0;
    int lat;

    initial begin
        reset   = 1'b0;
        rxo     = 1'b1;
        paritys = 1'b0;
        bauds   = 1'b1;
        dls     = 1'b1;
        repeat (5) @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_data",   {24'h0, rx_data}, 32'h0);
        check("rst_valid",  {31'h0, rx_valid}, 32'h0);
        check("rst_perr",   {31'h0, parity_err}, 32'h0);
        check("rst_ferr",   {31'h0, frame_err}, 32'h0);
        check("rst_busy",   {31'h0, rx_busy}, 32'h0);
        reset = 1'b1;
        hold(1'b1, 20);

        // ---------------- 8N1 0xA5 at 115200 ----------------
        // Start sample at +220 cycles (2 sync + 1 detect + 217 half bit),
        // stop sample 9 bits later: 220 + 9*434 = 4126 (~434*9.5).
        base = n_strobe;
        c0   = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, C_FAST);
        hold(1'b1, 50);
        lat = strobe_cyc - c0;
        check("a5_count", n_strobe, base + 1);
        check("a5_data",  {24'h0, cap_data}, 32'hA5);
        check("a5_perr",  {31'h0, cap_perr}, 32'h0);
        check("a5_ferr",  {31'h0, cap_ferr}, 32'h0);
        check("a5_latency_window", {31'h0, (lat >= 4121 && lat <= 4131)}, 32'h1);

        // ---------------- 7E1 0x41 (two ones -> parity bit 0) ----------------
        dls     = 1'b0;
        paritys = 1'b1;
        base    = n_strobe;
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, C_FAST);
        hold(1'b1, 50);
        check("p_ok_count", n_strobe, base + 1);
        check("p_ok_data",  {24'h0, cap_data}, 32'h41);
        check("p_ok_perr",  {31'h0, cap_perr}, 32'h0);
        check("p_ok_ferr",  {31'h0, cap_ferr}, 32'h0);

        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, C_FAST);
        hold(1'b1, 50);
        check("p_bad_count", n_strobe, base + 2);
        check("p_bad_data",  {24'h0, cap_data}, 32'h41);
        check("p_bad_perr",  {31'h0, cap_perr}, 32'h1);

        // ---------------- frame error then break ----------------
        dls     = 1'b1;
        paritys = 1'b0;
        base    = n_strobe;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, C_FAST);
        hold(1'b0, 3 * C_FAST);
        check("fe_count", n_strobe, base + 1);
        check("fe_data",  {24'h0, cap_data}, 32'h3C);
        check("fe_ferr",  {31'h0, cap_ferr}, 32'h1);
        check("fe_break_idle", {31'h0, rx_busy}, 32'h0);
        hold(1'b1, C_FAST);
        check("fe_no_extra", n_strobe, base + 1);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, C_FAST);
        hold(1'b1, 50);
        check("fe_recover_count", n_strobe, base + 2);
        check("fe_recover_data",  {24'h0, cap_data}, 32'h96);
        check("fe_recover_ferr",  {31'h0, cap_ferr}, 32'h0);

        // ---------------- 100-cycle glitch ----------------
        // START entered at +3, half-bit sample at +220 sees line high.
        base = n_strobe;
        rxo  = 1'b0;
        repeat (50) @(negedge clk);
        check("gl_busy_high", {31'h0, rx_busy}, 32'h1);
        repeat (50) @(negedge clk);
        rxo = 1'b1;
        repeat (120) @(negedge clk);
        check("gl_busy_low", {31'h0, rx_busy}, 32'h0);
        hold(1'b1, 100);
        check("gl_no_strobe", n_strobe, base);

        // ---------------- square wave, 434 cycles per half ----------------
        // Low start, then data H L H L H L H L (LSB first) = 0x55, stop high;
        // the next low half is the following start bit.
        base = n_strobe;
        for (int f = 0; f < 3; f++) begin
            for (int h = 0; h < 10; h++) hold(h[0], C_FAST);
            check("sq_count", n_strobe, base + f + 1);
            check("sq_data",  {24'h0, cap_data}, 32'h55);
            check("sq_ferr",  {31'h0, cap_ferr}, 32'h0);
        end
        hold(1'b1, 50);

        // ---------------- reset mid-frame at 9600 ----------------
        bauds = 1'b0;
        base  = n_strobe;
        hold(1'b0, C_SLOW);
        hold(1'b0, C_SLOW);
        hold(1'b1, C_SLOW / 2);
        check("rs_busy_mid", {31'h0, rx_busy}, 32'h1);
        reset = 1'b0;
        rxo   = 1'b1;
        repeat (3) @(negedge clk);
        check("rs_low_data",  {24'h0, rx_data}, 32'h0);
        check("rs_low_valid", {31'h0, rx_valid}, 32'h0);
        check("rs_low_perr",  {31'h0, parity_err}, 32'h0);
        check("rs_low_ferr",  {31'h0, frame_err}, 32'h0);
        check("rs_low_busy",  {31'h0, rx_busy}, 32'h0);
        reset = 1'b1;
        bauds = 1'b1;
        hold(1'b1, 30);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, C_FAST);
        hold(1'b1, 50);
        check("rs_count", n_strobe, base + 1);
        check("rs_data",  {24'h0, cap_data}, 32'h5A);
        check("rs_ferr",  {31'h0, cap_ferr}, 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
